// File: rtl/spi_pkg.sv
// Shared types and default sizing for the SPI transmit queue and its master wrapper.
package spi_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LOAD      = 2'd1,
        WAIT_DONE = 2'd2
    } spi_state_t;

    localparam int SPI_DEPTH  = 8;
    localparam int SPI_DATA_W = 8;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with an array-based store and a registered head output updated on pop.
module sync_fifo
    import spi_pkg::*;
#(
    parameter int DEPTH  = SPI_DEPTH,
    parameter int DATA_W = SPI_DATA_W,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout,
    output logic              full,
    output logic              empty,
    output logic [AW:0]       level
);

    localparam logic [AW:0]   LVL_FULL = DEPTH[AW:0];
    localparam logic [AW:0]   LVL_ONE  = 1;
    localparam logic [AW-1:0] PTR_ONE  = 1;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [AW:0]       r_level;
    logic [DATA_W-1:0] r_dout;

    logic w_full;
    logic w_empty;
    logic w_pop_ok;
    logic w_push_ok;

    assign w_full    = (r_level == LVL_FULL);
    assign w_empty   = (r_level == '0);
    assign w_pop_ok  = pop & ~w_empty;
    // A pop in the same cycle frees a slot, so a push into a full FIFO is still accepted.
    assign w_push_ok = push & (~w_full | w_pop_ok);

    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
            r_dout   <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
                r_dout   <= r_mem[r_rd_ptr];
            end
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_level <= r_level + LVL_ONE;
                2'b01:   r_level <= r_level - LVL_ONE;
                default: r_level <= r_level;
            endcase
        end
    end

    assign dout  = r_dout;
    assign full  = w_full;
    assign empty = w_empty;
    assign level = r_level;

endmodule

// File: rtl/spi_tx_queue.sv
// Byte queue feeding the SPI master: pops one byte, strobes load for a cycle, waits for busy to drop.
module spi_tx_queue
    import spi_pkg::*;
#(
    parameter int DEPTH  = SPI_DEPTH,
    parameter int DATA_W = SPI_DATA_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic                     wr_en,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow,
    input  logic                     ovf_clr,
    input  logic                     enable,
    output logic [DATA_W-1:0]        spi_data,
    output logic                     spi_load,
    input  logic                     spi_busy,
    output logic                     byte_done,
    output logic                     idle
);

    spi_state_t r_state;
    logic       r_spi_load;
    logic       r_overflow;

    logic                   w_full;
    logic                   w_empty;
    logic                   w_pop;
    logic                   w_ovf_set;
    logic [DATA_W-1:0]      w_fifo_dout;
    logic [$clog2(DEPTH):0] w_level;

    assign w_pop     = (r_state == IDLE) & enable & ~w_empty;
    assign w_ovf_set = wr_en & w_full & ~w_pop;

    sync_fifo #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (wr_en),
        .pop   (w_pop),
        .din   (wr_data),
        .dout  (w_fifo_dout),
        .full  (w_full),
        .empty (w_empty),
        .level (w_level)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= IDLE;
            r_spi_load <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_pop) begin
                        r_state    <= LOAD;
                        r_spi_load <= 1'b1;
                    end
                end
                LOAD: begin
                    r_state    <= WAIT_DONE;
                    r_spi_load <= 1'b0;
                end
                WAIT_DONE: begin
                    if (!spi_busy) begin
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_state    <= IDLE;
                    r_spi_load <= 1'b0;
                end
            endcase
        end
    end

    // Setting wins over clearing so a write-while-full is never lost.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_overflow <= 1'b0;
        end else if (w_ovf_set) begin
            r_overflow <= 1'b1;
        end else if (ovf_clr) begin
            r_overflow <= 1'b0;
        end
    end

    // byte_done must coincide with the cycle busy is seen low, so it is decoded from state and busy.
    assign byte_done = (r_state == WAIT_DONE) & ~spi_busy;
    assign idle      = (r_state == IDLE) & w_empty;
    assign spi_load  = r_spi_load;
    assign spi_data  = w_fifo_dout;
    assign full      = w_full;
    assign empty     = w_empty;
    assign level     = w_level;
    assign overflow  = r_overflow;

endmodule

// File: tb/tb_spi_tx_queue.sv
// Directed bench for spi_tx_queue with a behavioural 8-bit MSB-first SPI master model.
module tb_spi_tx_queue;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       wr_en = 1'b0;
    logic       ovf_clr = 1'b0;
    logic       enable = 1'b0;
    logic       spi_busy;
    logic       full;
    logic       empty;
    logic [3:0] level;
    logic       overflow;
    logic [7:0] spi_data;
    logic       spi_load;
    logic       byte_done;
    logic       idle;

    spi_tx_queue #(.DEPTH(8), .DATA_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .wr_data   (wr_data),
        .wr_en     (wr_en),
        .full      (full),
        .empty     (empty),
        .level     (level),
        .overflow  (overflow),
        .ovf_clr   (ovf_clr),
        .enable    (enable),
        .spi_data  (spi_data),
        .spi_load  (spi_load),
        .spi_busy  (spi_busy),
        .byte_done (byte_done),
        .idle      (idle)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Master model: samples load, raises busy next cycle, shifts 8 bits MSB-first.
    logic [7:0] m_sh;
    logic [7:0] m_recv;
    logic [3:0] m_cnt;
    logic [7:0] rx_q [$];

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_cnt    <= 4'd0;
            m_sh     <= 8'h00;
            m_recv   <= 8'h00;
            spi_busy <= 1'b0;
        end else if (m_cnt != 4'd0) begin
            m_recv   <= {m_recv[6:0], m_sh[7]};
            m_sh     <= {m_sh[6:0], 1'b0};
            m_cnt    <= m_cnt - 4'd1;
            spi_busy <= (m_cnt != 4'd1);
            if (m_cnt == 4'd1) rx_q.push_back({m_recv[6:0], m_sh[7]});
        end else if (spi_load) begin
            m_sh     <= spi_data;
            m_cnt    <= 4'd8;
            spi_busy <= 1'b1;
        end
    end

    logic [7:0] load_q [$];
    int         load_cyc [$];
    int         done_cyc [$];

    always @(negedge clk) begin
        if (spi_load === 1'b1) begin
            load_q.push_back(spi_data);
            load_cyc.push_back(cyc);
            $display("load  data=%h cycle=%0d level=%0d", spi_data, cyc, level);
        end
        if (byte_done === 1'b1) begin
            done_cyc.push_back(cyc);
            $display("done  cycle=%0d", cyc);
        end
    end

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_byte(input logic [7:0] d);
        wr_data = d;
        wr_en   = 1'b1;
        tick(1);
        wr_en   = 1'b0;
    endtask

    initial begin
        int w;
        int bl;
        int bd;
        int br;
        int lvl_max;
        logic [7:0] exp4 [9];
        exp4 = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17, 8'h20};

        // Reset, then idle with enable high and nothing written
        enable = 1'b1;
        tick(3);
        check("rst_empty", empty, 1);
        check("rst_full", full, 0);
        check("rst_level", level, 0);
        check("rst_overflow", overflow, 0);
        check("rst_idle", idle, 1);
        check("rst_load", spi_load, 0);
        check("rst_data", spi_data, 0);
        check("rst_done", byte_done, 0);
        rst = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            check("idle_empty", empty, 1);
            check("idle_level", level, 0);
            check("idle_idle", idle, 1);
            check("idle_load", spi_load, 0);
        end

        // Single byte
        bl = load_q.size(); bd = done_cyc.size(); br = rx_q.size();
        w = cyc;
        push_byte(8'hA5);
        tick(14);
        check("one_nloads", load_q.size() - bl, 1);
        check("one_data", load_q[bl], 8'hA5);
        check("one_load_lat", load_cyc[bl] - w, 2);
        check("one_ndone", done_cyc.size() - bd, 1);
        check("one_done_lat", done_cyc[bd] - load_cyc[bl], 9);
        check("one_shifted", rx_q[br], 8'hA5);
        check("one_idle", idle, 1);

        // Burst 01..08 with enable high
        bl = load_q.size(); bd = done_cyc.size(); br = rx_q.size();
        w = cyc;
        lvl_max = 0;
        for (int i = 1; i <= 8; i++) begin
            wr_data = 8'(i);
            wr_en   = 1'b1;
            tick(1);
            if (int'(level) > lvl_max) lvl_max = int'(level);
        end
        wr_en = 1'b0;
        for (int i = 0; i < 92; i++) begin
            tick(1);
            if (int'(level) > lvl_max) lvl_max = int'(level);
        end
        check("burst_lvl_peak", (lvl_max >= 7 && lvl_max <= 8), 1);
        check("burst_nloads", load_q.size() - bl, 8);
        check("burst_first_lat", load_cyc[bl] - w, 2);
        for (int k = 0; k < 8; k++) begin
            check("burst_data", load_q[bl + k], 32'(k + 1));
            check("burst_shifted", rx_q[br + k], 32'(k + 1));
            if (k > 0) check("burst_period", load_cyc[bl + k] - load_cyc[bl + k - 1], 11);
        end
        check("burst_ndone", done_cyc.size() - bd, 8);
        check("burst_empty", empty, 1);

        // Overflow with launching disabled
        enable = 1'b0;
        bl = load_q.size();
        for (int i = 0; i < 9; i++) push_byte(8'h10 + 8'(i));
        check("ovf_full", full, 1);
        check("ovf_level", level, 8);
        check("ovf_flag", overflow, 1);
        check("ovf_noload", load_q.size() - bl, 0);
        ovf_clr = 1'b1; tick(1); ovf_clr = 1'b0;
        check("ovf_cleared", overflow, 0);
        wr_data = 8'h19; wr_en = 1'b1; ovf_clr = 1'b1;
        tick(1);
        wr_en = 1'b0; ovf_clr = 1'b0;
        check("ovf_set_beats_clr", overflow, 1);
        check("ovf_level_hold", level, 8);
        ovf_clr = 1'b1; tick(1); ovf_clr = 1'b0;
        check("ovf_cleared2", overflow, 0);
        // Write in the same cycle as the pop from a full FIFO is accepted
        enable = 1'b1;
        wr_data = 8'h20; wr_en = 1'b1;
        tick(1);
        wr_en = 1'b0;
        check("fullpop_ovf", overflow, 0);
        check("fullpop_level", level, 8);
        check("fullpop_full", full, 1);
        tick(105);
        check("ovf_nloads", load_q.size() - bl, 9);
        for (int k = 0; k < 9; k++) check("ovf_stream", load_q[bl + k], exp4[k]);
        check("ovf_drained", empty, 1);

        // Enable gating: drop enable during the first transfer
        enable = 1'b0;
        bl = load_q.size(); bd = done_cyc.size();
        push_byte(8'h31);
        push_byte(8'h32);
        push_byte(8'h33);
        enable = 1'b1;
        tick(3);
        enable = 1'b0;
        tick(20);
        check("gate_nloads", load_q.size() - bl, 1);
        check("gate_data", load_q[bl], 8'h31);
        check("gate_ndone", done_cyc.size() - bd, 1);
        check("gate_level", level, 2);
        check("gate_notidle", idle, 0);
        tick(20);
        check("gate_hold_loads", load_q.size() - bl, 1);
        check("gate_hold_level", level, 2);
        enable = 1'b1;
        tick(30);
        check("gate_resume_loads", load_q.size() - bl, 3);
        check("gate_resume_d1", load_q[bl + 1], 8'h32);
        check("gate_resume_d2", load_q[bl + 2], 8'h33);
        check("gate_resume_level", level, 0);
        check("gate_resume_idle", idle, 1);

        // Reset during WAIT_DONE with two bytes still queued
        enable = 1'b0;
        push_byte(8'h41);
        push_byte(8'h42);
        push_byte(8'h43);
        enable = 1'b1;
        tick(5);
        check("midrst_pre_level", level, 2);
        check("midrst_pre_busy", spi_busy, 1);
        bl = load_q.size(); bd = done_cyc.size();
        #3;
        rst = 1'b0;
        #1;
        check("midrst_load", spi_load, 0);
        check("midrst_level", level, 0);
        check("midrst_empty", empty, 1);
        check("midrst_idle", idle, 1);
        check("midrst_done", byte_done, 0);
        tick(3);
        rst = 1'b1;
        tick(20);
        check("midrst_no_done", done_cyc.size() - bd, 0);
        check("midrst_no_load", load_q.size() - bl, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/spi_tx_queue.md
Name: spi_tx_queue

Overview:
- Byte queue and launch sequencer sitting directly upstream of the simple SPI master.
- The processor side pushes bytes into a FIFO. The block pops them one at a time, presents each byte on the master's data input with a one-cycle load strobe, then waits for the master's busy to drop before launching the next byte.
- It reports FIFO level and status, a per-byte completion pulse, and a sticky overflow flag.
- It runs on the same clock that drives the master's shift clock.

Parameters:
- DEPTH, 8: FIFO entries; power of two, at least 2.
- DATA_W, 8: byte width; must match the master's data width.

Ports:
- clk  in  1  block clock; same net as the master's shift clock.
- rst  in  1  asynchronous reset, active-low.
- wr_data  in  DATA_W  byte to enqueue.
- wr_en  in  1  enqueue strobe, one byte per cycle.
- full  out  1  FIFO holds DEPTH bytes.
- empty  out  1  FIFO holds 0 bytes.
- level  out  $clog2(DEPTH)+1  current FIFO occupancy.
- overflow  out  1  sticky: a write was attempted while full.
- ovf_clr  in  1  clears overflow.
- enable  in  1  permits launching new bytes.
- spi_data  out  DATA_W  to master data.
- spi_load  out  1  to master load_data.
- spi_busy  in  1  from master busy.
- byte_done  out  1  one-cycle pulse when a launched byte has finished shifting.
- idle  out  1  state is IDLE and FIFO is empty.

Behaviour:
- Reset (rst low, asynchronous):
  - state = IDLE; FIFO pointers and level = 0.
  - empty = 1, full = 0, overflow = 0.
  - spi_load = 0, spi_data = 0, byte_done = 0, idle = 1.
  - Reset mid-transfer abandons the byte. The integrator must reset the master in the same cycle.
- FIFO:
  - Write accepted when wr_en & ~full.
  - Write while full: data dropped, overflow set. The set takes priority over ovf_clr in the same cycle.
  - A written byte is visible to the pop side the cycle after the write; there is no bypass.
  - Write and pop in the same cycle: level unchanged, both take effect. This includes the full case, where the write is accepted because the pop frees a slot.
  - Pointers wrap modulo DEPTH.
- FSM states:
  - IDLE: if enable & ~empty, pop the head into the spi_data register and go to LOAD. Otherwise stay.
  - LOAD: spi_load = 1 for exactly this cycle; spi_data is stable. Next state is WAIT_DONE, unconditionally.
  - WAIT_DONE: spi_load = 0. When spi_busy = 0, assert byte_done for one cycle and go to IDLE. Otherwise stay.
- Timing:
  - The master samples load at the LOAD edge and asserts busy in the following cycle.
  - WAIT_DONE therefore normally sees busy high for 8 cycles.
  - Byte-to-byte launch period is 11 cycles (IDLE 1, LOAD 1, WAIT_DONE 9).
- spi_data holds its last value after a transfer; there is no clearing.
- Deasserting enable mid-transfer does not abort. The current byte completes and no new byte is popped.
- Master stuck idle: if busy is already low on the first WAIT_DONE cycle, byte_done pulses immediately. This is not an error.
- level = write count minus read count, saturating by construction at DEPTH.

Decomposition:
- Package spi_pkg holds:
  - the state enum (IDLE, LOAD, WAIT_DONE; 2-bit logic);
  - the default DEPTH and DATA_W constants shared with the master wrapper.
- One sub-module, sync_fifo:
  - parameterised DEPTH/DATA_W;
  - ports: push, pop, din, dout, full, empty, level;
  - asynchronous active-low reset;
  - dout is the registered head, updated on pop.

Test Plan:
- Reset then idle: hold rst low, release. Required: empty=1, level=0, idle=1, spi_load=0 for 20 cycles, with enable=1 and no writes.
- Single byte: write 8'hA5 with enable=1. Required:
  - spi_load high exactly 1 cycle, 2 cycles after the write;
  - spi_data=8'hA5 during the load;
  - the master model shifts out A5 MSB-first;
  - byte_done pulses 9 cycles after spi_load;
  - idle=1 afterwards.
- Burst and ordering: write 8'h01..8'h08 back-to-back. Required:
  - level peaks at 7 or 8;
  - eight loads in order 01..08, each 11 cycles apart;
  - eight byte_done pulses, then empty=1.
- Overflow: enable=0, write DEPTH+1 bytes. Required:
  - full=1, level=DEPTH, overflow=1;
  - the extra byte is absent from the output stream;
  - a ovf_clr pulse clears overflow;
  - a simultaneous write-while-full plus ovf_clr leaves overflow=1.
- Enable gating: with 3 bytes queued, drop enable during the first transfer. Required: that byte completes with one byte_done, no further loads, and level=2 until enable returns.
- Reset mid-transfer: assert rst during WAIT_DONE with 2 bytes queued. Required: spi_load=0, level=0, empty=1 immediately (asynchronously), and no byte_done pulse.
